// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port ids, per-port wait FSM
// states and the in-flight read tracking entry.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_st_e;

    typedef struct packed {
        logic  valid;
        port_e port;
    } rd_ent_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: a lone requester wins; a tie goes to A under fixed priority,
// otherwise to the port that was not granted most recently.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fixed_prio,
    input  logic [1:0] req,
    output logic [1:0] win
);

    port_e last_grant;

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = (fixed_prio || last_grant == PORT_B) ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    // Starts at B so the first tie after reset goes to A.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= PORT_B;
        else if (win[0])
            last_grant <= PORT_A;
        else if (win[1])
            last_grant <= PORT_B;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the 1024x8 single-write / dual-read-output memory between requesters
// A and B: one registered command per clock, read data returned 3 cycles after req.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              b_req,
    input  logic              a_we,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    input  logic [DATA_W-1:0] mem_data_a,
    input  logic [DATA_W-1:0] mem_data_b,
    output logic [ADDR_W-1:0] iAddress,
    output logic [DATA_W-1:0] validdata,
    output logic              iWriteEnable,
    output logic              Readtoa,
    output logic              Readtob
);

    logic [1:0]             req, we, win;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic                   sel, any_win;
    rd_ent_t                rd_pipe [2];

    assign req     = {b_req, a_req};
    assign we      = {b_we, a_we};
    assign addr    = {b_addr, a_addr};
    assign wdata   = {b_wdata, a_wdata};
    assign sel     = win[1];
    assign any_win = |win;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .fixed_prio (FIXED_PRIO != 0),
        .req        (req),
        .win        (win)
    );

    // Wait tracking per port; only observed by the starvation check.
    for (genvar p = 0; p < 2; p++) begin : g_port
        arb_st_e st;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                st <= IDLE;
            else
                case (st)
                    IDLE:    if (req[p] && !win[p]) st <= WAIT;
                    WAIT:    if (win[p]) st <= IDLE;
                    default: st <= IDLE;
                endcase
        end

        a_no_starve: assert property (@(posedge clk) disable iff (!reset_n)
            (FIXED_PRIO == 0 && st == WAIT && req[p]) |-> win[p]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            a_rvalid     <= 1'b0;
            b_rvalid     <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            iAddress     <= '0;
            validdata    <= '0;
            iWriteEnable <= 1'b0;
            Readtoa      <= 1'b0;
            Readtob      <= 1'b0;
            rd_pipe[0]   <= '0;
            rd_pipe[1]   <= '0;
        end else begin
            a_gnt        <= win[0];
            b_gnt        <= win[1];
            iWriteEnable <= any_win & we[sel];
            Readtoa      <= win[0] & ~we[0];
            Readtob      <= win[1] & ~we[1];
            if (any_win)
                iAddress <= addr[sel];
            if (any_win && we[sel])
                validdata <= wdata[sel];

            // Stage 0: command on the bus; stage 1: memory output valid next cycle.
            rd_pipe[0] <= '{valid: any_win & ~we[sel], port: port_e'(sel)};
            rd_pipe[1] <= rd_pipe[0];

            a_rvalid <= rd_pipe[1].valid && rd_pipe[1].port == PORT_A;
            b_rvalid <= rd_pipe[1].valid && rd_pipe[1].port == PORT_B;
            if (rd_pipe[1].valid && rd_pipe[1].port == PORT_A)
                a_rdata <= mem_data_a;
            if (rd_pipe[1].valid && rd_pipe[1].port == PORT_B)
                b_rdata <= mem_data_b;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance driving a behavioural 1024x8 memory,
// plus a fixed-priority instance sharing the same requester inputs.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_req, b_req, a_we, b_we;
    logic [9:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] mem_data_a, mem_data_b;
    logic [9:0] iAddress;
    logic [7:0] validdata;
    logic       iWriteEnable, Readtoa, Readtob;

    logic       p_a_gnt, p_b_gnt, p_a_rvalid, p_b_rvalid;
    logic [7:0] p_a_rdata, p_b_rdata;
    logic [9:0] p_iAddress;
    logic [7:0] p_validdata;
    logic       p_iWriteEnable, p_Readtoa, p_Readtob;

    logic [7:0] mem [1024];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .iAddress(iAddress), .validdata(validdata), .iWriteEnable(iWriteEnable),
        .Readtoa(Readtoa), .Readtob(Readtob)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(p_a_gnt), .b_gnt(p_b_gnt), .a_rvalid(p_a_rvalid), .b_rvalid(p_b_rvalid),
        .a_rdata(p_a_rdata), .b_rdata(p_b_rdata),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .iAddress(p_iAddress), .validdata(p_validdata), .iWriteEnable(p_iWriteEnable),
        .Readtoa(p_Readtoa), .Readtob(p_Readtob)
    );

    // Memory: write and read sampled at the clock edge, read data one cycle later.
    always @(posedge clk) begin
        if (iWriteEnable) mem[iAddress] <= validdata;
        if (Readtoa) mem_data_a <= mem[iAddress];
        if (Readtob) mem_data_b <= mem[iAddress];
    end

    task automatic idle_inputs();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk); reset_n = 0; idle_inputs();
        @(negedge clk);
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, iAddress, validdata,
             iWriteEnable, Readtoa, Readtob} !== 41'd0) begin
            bad++; $display("FAIL reset_outputs got nonzero gnt=%b%b addr=%0h", a_gnt, b_gnt, iAddress);
        end
        total++;
        if ({p_a_gnt, p_b_gnt, p_iWriteEnable, p_Readtoa, p_Readtob} !== 5'd0) begin
            bad++; $display("FAIL reset_fp_outputs got=%b exp=0",
                {p_a_gnt, p_b_gnt, p_iWriteEnable, p_Readtoa, p_Readtob});
        end
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_write_read();
        @(negedge clk); a_req = 1; a_we = 1; a_addr = 10'd0; a_wdata = 8'd8;
        @(negedge clk);
        total++;
        if ({a_gnt, iWriteEnable, Readtoa, Readtob} !== 4'b1100) begin
            bad++; $display("FAIL wr_cmd got=%b exp=1100", {a_gnt, iWriteEnable, Readtoa, Readtob});
        end
        total++;
        if ({iAddress, validdata} !== {10'd0, 8'd8}) begin
            bad++; $display("FAIL wr_bus got addr=%0h data=%0h exp addr=0 data=8", iAddress, validdata);
        end
        a_we = 0;
        @(negedge clk);
        total++;
        if ({a_gnt, iWriteEnable, Readtoa, Readtob} !== 4'b1010) begin
            bad++; $display("FAIL rd_cmd got=%b exp=1010", {a_gnt, iWriteEnable, Readtoa, Readtob});
        end
        a_req = 0;
        @(negedge clk);
        total++;
        if ({a_rvalid, a_gnt, Readtoa} !== 3'b000) begin
            bad++; $display("FAIL rd_early got=%b exp=000", {a_rvalid, a_gnt, Readtoa});
        end
        @(negedge clk);
        total++;
        if ({a_rvalid, a_rdata} !== {1'b1, 8'd8}) begin
            bad++; $display("FAIL rd_return got v=%b d=%0d exp v=1 d=8", a_rvalid, a_rdata);
        end
        @(negedge clk);
        total++;
        if ({a_rvalid, a_rdata} !== {1'b0, 8'd8}) begin
            bad++; $display("FAIL rd_hold got v=%b d=%0d exp v=0 d=8", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        a_req = 1; a_we = 1; a_addr = 10'd10; a_wdata = 8'd16;
        b_req = 1; b_we = 0; b_addr = 10'd10;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, iWriteEnable} !== 3'b101) begin
            bad++; $display("FAIL tie_first got=%b exp=101", {a_gnt, b_gnt, iWriteEnable});
        end
        a_req = 0;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt, Readtob, Readtoa} !== 4'b0110) begin
            bad++; $display("FAIL tie_second got=%b exp=0110", {a_gnt, b_gnt, Readtob, Readtoa});
        end
        b_req = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({b_rvalid, a_rvalid, b_rdata} !== {2'b10, 8'd16}) begin
            bad++; $display("FAIL tie_rdata got v=%b%b d=%0d exp v=10 d=16", b_rvalid, a_rvalid, b_rdata);
        end
    endtask

    task automatic test_sustained();
        logic [1:0] exp_rr;
        apply_reset();
        a_req = 1; a_addr = 10'd5; b_req = 1; b_addr = 10'd6;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_rr = (i % 2 == 0) ? 2'b10 : 2'b01;
            total++;
            if ({a_gnt, b_gnt} !== exp_rr) begin
                bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {a_gnt, b_gnt}, exp_rr);
            end
            total++;
            if ({p_a_gnt, p_b_gnt} !== 2'b10) begin
                bad++; $display("FAIL fp_grant[%0d] got=%b exp=10", i, {p_a_gnt, p_b_gnt});
            end
            total++;
            if ({Readtoa, Readtob} !== exp_rr) begin
                bad++; $display("FAIL rr_strobe[%0d] got=%b exp=%b", i, {Readtoa, Readtob}, exp_rr);
            end
        end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_pipelined();
        logic [2:0] exp_cmd;
        logic [1:0] exp_rv;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k)
                1, 2:    exp_cmd = 3'b100;
                3:       exp_cmd = 3'b010;
                4:       exp_cmd = 3'b001;
                default: exp_cmd = 3'b000;
            endcase
            exp_rv = (k == 5) ? 2'b10 : (k == 6) ? 2'b01 : 2'b00;
            total++;
            if ({iWriteEnable, Readtoa, Readtob} !== exp_cmd) begin
                bad++; $display("FAIL pipe_cmd[%0d] got=%b exp=%b", k, {iWriteEnable, Readtoa, Readtob}, exp_cmd);
            end
            total++;
            if ({a_rvalid, b_rvalid} !== exp_rv) begin
                bad++; $display("FAIL pipe_rvalid[%0d] got=%b exp=%b", k, {a_rvalid, b_rvalid}, exp_rv);
            end
            if (k == 4) begin
                total++;
                if (iAddress !== 10'h3FF) begin
                    bad++; $display("FAIL pipe_addr got=%0h exp=3ff", iAddress);
                end
            end
            if (k == 5) begin
                total++;
                if (a_rdata !== 8'd32) begin
                    bad++; $display("FAIL pipe_a_rdata got=%0d exp=32", a_rdata);
                end
            end
            if (k == 6) begin
                total++;
                if (b_rdata !== 8'd64) begin
                    bad++; $display("FAIL pipe_b_rdata got=%0d exp=64", b_rdata);
                end
            end
            idle_inputs();
            case (k)
                0: begin a_req = 1; a_we = 1; a_addr = 10'h01F; a_wdata = 8'd32; end
                1: begin b_req = 1; b_we = 1; b_addr = 10'h3FF; b_wdata = 8'd64; end
                2: begin a_req = 1; a_addr = 10'h01F; end
                3: begin b_req = 1; b_addr = 10'h3FF; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); a_req = 1; a_we = 0; a_addr = 10'h01F;
        @(negedge clk);
        total++;
        if (a_gnt !== 1'b1) begin
            bad++; $display("FAIL mid_gnt got=%b exp=1", a_gnt);
        end
        @(negedge clk);
        total++;
        if ({a_gnt, Readtoa, a_rdata} !== {2'b11, 8'd32}) begin
            bad++; $display("FAIL mid_pre got g=%b r=%b d=%0d exp g=1 r=1 d=32", a_gnt, Readtoa, a_rdata);
        end
        reset_n = 0; idle_inputs();
        #1;
        total++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, iAddress, validdata,
             iWriteEnable, Readtoa, Readtob} !== 41'd0) begin
            bad++; $display("FAIL mid_async_clear got g=%b addr=%0h d=%0d exp all 0", a_gnt, iAddress, a_rdata);
        end
        @(negedge clk);
        @(negedge clk); reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({a_rvalid, a_rdata} !== 9'd0) begin
                bad++; $display("FAIL mid_no_rvalid[%0d] got v=%b d=%0d exp v=0 d=0", i, a_rvalid, a_rdata);
            end
        end
        a_req = 1; b_req = 1; a_addr = 10'd1; b_addr = 10'd2;
        @(negedge clk);
        total++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            bad++; $display("FAIL mid_first_tie got=%b exp=10", {a_gnt, b_gnt});
        end
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
        mem_data_a = 8'd0;
        mem_data_b = 8'd0;
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_simultaneous();
        test_sustained();
        test_pipelined();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
